// File: rtl/aes_encipher_block_pkg.sv
// Purpose: shared AES constants, state encodings and GF(2^8)/S-box helpers.
// Latency: n/a, declarations and pure combinational functions only.
// Backpressure: n/a.
package aes_encipher_block_pkg;

    localparam logic       AES_128_BIT_KEY = 1'b0;
    localparam logic       AES_256_BIT_KEY = 1'b1;
    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;

    localparam logic [1:0] CTRL_IDLE = 2'd0;
    localparam logic [1:0] CTRL_INIT = 2'd1;
    localparam logic [1:0] CTRL_SBOX = 2'd2;
    localparam logic [1:0] CTRL_MAIN = 2'd3;

    typedef enum logic [2:0] {
        NO_UPDATE    = 3'd0,
        INIT_UPDATE  = 3'd1,
        SBOX_UPDATE  = 3'd2,
        MAIN_UPDATE  = 3'd3,
        FINAL_UPDATE = 3'd4
    } upd_e;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        return SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [31:0] w0, w1, w2, w3;
        w0 = s[127:96];
        w1 = s[95:64];
        w2 = s[63:32];
        w3 = s[31:0];
        return {{w0[31:24], w1[23:16], w2[15:8], w3[7:0]},
                {w1[31:24], w2[23:16], w3[15:8], w0[7:0]},
                {w2[31:24], w3[23:16], w0[15:8], w1[7:0]},
                {w3[31:24], w0[23:16], w1[15:8], w2[7:0]}};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]),
                mix_word(s[63:32]),  mix_word(s[31:0])};
    endfunction

endpackage

// File: rtl/aes_encipher_block_sbox.sv
// Purpose: four parallel forward S-box byte lookups on one 32-bit word.
// Latency: purely combinational.
// Backpressure: none, output follows input.
module aes_encipher_block_sbox
    import aes_encipher_block_pkg::*;
(
    input  logic [31:0] sword_i,
    output logic [31:0] new_sword_o
);

    assign new_sword_o = {sbox_byte(sword_i[31:24]), sbox_byte(sword_i[23:16]),
                          sbox_byte(sword_i[15:8]),  sbox_byte(sword_i[7:0])};

endmodule

// File: rtl/aes_encipher_block.sv
// Purpose: iterative AES-128/256 encryption, one S-box word per cycle.
// Latency: 2 + 5*rounds edges from accepted next to ready (52 / 72 cycles).
// Backpressure: next ignored while ready=0; result held until next INIT.
module aes_encipher_block
    import aes_encipher_block_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    // Word 0 is index 0 and sits in bits [127:96].
    logic [0:3][31:0] st_q, st_d;
    logic [3:0]       st_we;
    logic [1:0]       sword_ctr_q, sword_ctr_d;
    logic             sword_ctr_we;
    logic [3:0]       round_ctr_q, round_ctr_d;
    logic             round_ctr_we;
    logic             ready_q, ready_d, ready_we;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             ctrl_we;
    upd_e             upd;
    logic [31:0]      sbox_out;
    logic [3:0]       num_rounds;

    assign num_rounds = (keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
    assign round      = round_ctr_q;
    assign new_block  = st_q;
    assign ready      = ready_q;

    aes_encipher_block_sbox u_sbox (
        .sword_i     (st_q[sword_ctr_q]),
        .new_sword_o (sbox_out)
    );

    // All state registers, each loaded only when its write enable is set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q        <= '0;
            sword_ctr_q <= 2'd0;
            round_ctr_q <= 4'd0;
            ready_q     <= 1'b1;
            ctrl_q      <= CTRL_IDLE;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (st_we[i]) st_q[i] <= st_d[i];
            end
            if (sword_ctr_we) sword_ctr_q <= sword_ctr_d;
            if (round_ctr_we) round_ctr_q <= round_ctr_d;
            if (ready_we)     ready_q     <= ready_d;
            if (ctrl_we)      ctrl_q      <= ctrl_d;
        end
    end

    // Round datapath: whole-state loads for INIT/MAIN/FINAL, one word for SBOX.
    always_comb begin
        st_d  = st_q;
        st_we = 4'b0000;
        case (upd)
            INIT_UPDATE: begin
                st_d  = block ^ round_key;
                st_we = 4'b1111;
            end
            SBOX_UPDATE: begin
                st_d[sword_ctr_q]  = sbox_out;
                st_we[sword_ctr_q] = 1'b1;
            end
            MAIN_UPDATE: begin
                st_d  = mix_columns(shift_rows(st_q)) ^ round_key;
                st_we = 4'b1111;
            end
            FINAL_UPDATE: begin
                st_d  = shift_rows(st_q) ^ round_key;
                st_we = 4'b1111;
            end
            default: ;
        endcase
    end

    // Control FSM: INIT, then per round four SBOX cycles and one MAIN cycle.
    always_comb begin
        upd          = NO_UPDATE;
        sword_ctr_d  = sword_ctr_q;
        sword_ctr_we = 1'b0;
        round_ctr_d  = round_ctr_q;
        round_ctr_we = 1'b0;
        ready_d      = ready_q;
        ready_we     = 1'b0;
        ctrl_d       = ctrl_q;
        ctrl_we      = 1'b0;
        case (ctrl_q)
            CTRL_IDLE: begin
                if (next) begin
                    round_ctr_d  = 4'd0;
                    round_ctr_we = 1'b1;
                    ready_d      = 1'b0;
                    ready_we     = 1'b1;
                    ctrl_d       = CTRL_INIT;
                    ctrl_we      = 1'b1;
                end
            end
            CTRL_INIT: begin
                upd          = INIT_UPDATE;
                round_ctr_d  = 4'd1;
                round_ctr_we = 1'b1;
                sword_ctr_d  = 2'd0;
                sword_ctr_we = 1'b1;
                ctrl_d       = CTRL_SBOX;
                ctrl_we      = 1'b1;
            end
            CTRL_SBOX: begin
                upd          = SBOX_UPDATE;
                sword_ctr_d  = sword_ctr_q + 2'd1;
                sword_ctr_we = 1'b1;
                if (sword_ctr_q == 2'd3) begin
                    ctrl_d  = CTRL_MAIN;
                    ctrl_we = 1'b1;
                end
            end
            CTRL_MAIN: begin
                sword_ctr_d  = 2'd0;
                sword_ctr_we = 1'b1;
                ctrl_we      = 1'b1;
                if (round_ctr_q < num_rounds) begin
                    upd          = MAIN_UPDATE;
                    round_ctr_d  = round_ctr_q + 4'd1;
                    round_ctr_we = 1'b1;
                    ctrl_d       = CTRL_SBOX;
                end else begin
                    upd      = FINAL_UPDATE;
                    ready_d  = 1'b1;
                    ready_we = 1'b1;
                    ctrl_d   = CTRL_IDLE;
                end
            end
            default: begin
                ctrl_d  = CTRL_IDLE;
                ctrl_we = 1'b1;
            end
        endcase
    end

endmodule
